// File: rtl/node_run_controller.sv
// node_run_controller: sequences one path-traversal run from the toggled run
// level. It synchronises run_req, issues a start pulse, counts node_reached
// events against the latched path length and raises a per-node watchdog fault.
module node_run_controller #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TMR_W          = 26
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       run_req,
    input  logic [5:0] num_nodes,
    input  logic       node_reached,
    output logic       start_pulse,
    output logic       run_active,
    output logic [5:0] node_idx,
    output logic       run_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_dly_q, req_dly_d;
    logic [5:0]             n_tgt_q, n_tgt_d;
    logic [5:0]             node_idx_q, node_idx_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   start_pulse_q, run_active_q, run_done_q, timeout_err_q;

    logic req_s;
    logic req_rise;
    logic req_fall;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_dly_q;
    assign req_fall = ~req_s & req_dly_q;

    // Synchroniser shift and edge-detect delay
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], run_req};
        req_dly_d = req_s;
    end

    // Run sequencing: next state, node counter, watchdog timer
    always_comb begin
        state_d    = state_q;
        n_tgt_d    = n_tgt_q;
        node_idx_d = node_idx_q;
        timer_d    = timer_q;

        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d    = START;
                    n_tgt_d    = num_nodes;
                    node_idx_d = '0;
                end
            end
            START: begin
                timer_d = '0;
                state_d = (n_tgt_q == 6'd0) ? DONE : RUN;
            end
            RUN: begin
                if (node_reached) begin
                    node_idx_d = node_idx_q + 6'd1;
                    timer_d    = '0;
                    if (node_idx_q + 6'd1 == n_tgt_q) begin
                        state_d = DONE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: ;
        endcase

        // A dropped request aborts any active run and outranks node events
        if (state_q != IDLE && req_fall) begin
            state_d    = IDLE;
            node_idx_d = '0;
            timer_d    = '0;
        end
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            req_dly_q     <= 1'b0;
            n_tgt_q       <= '0;
            node_idx_q    <= '0;
            timer_q       <= '0;
            start_pulse_q <= 1'b0;
            run_active_q  <= 1'b0;
            run_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            req_dly_q     <= req_dly_d;
            n_tgt_q       <= n_tgt_d;
            node_idx_q    <= node_idx_d;
            timer_q       <= timer_d;
            start_pulse_q <= (state_d == START);
            run_active_q  <= (state_d == RUN);
            run_done_q    <= (state_d == DONE);
            timeout_err_q <= (state_d == FAULT);
        end
    end

    assign start_pulse = start_pulse_q;
    assign run_active  = run_active_q;
    assign node_idx    = node_idx_q;
    assign run_done    = run_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_node_run_controller.sv
// Directed bench for node_run_controller with a short watchdog (16 cycles).
module tb_node_run_controller;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       run_req = 1'b0;
    logic [5:0] num_nodes = '0;
    logic       node_reached = 1'b0;
    logic       start_pulse;
    logic       run_active;
    logic [5:0] node_idx;
    logic       run_done;
    logic       timeout_err;

    int tests = 0;
    int failed = 0;

    node_run_controller #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16),
        .TMR_W         (5)
    ) dut (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .run_req     (run_req),
        .num_nodes   (num_nodes),
        .node_reached(node_reached),
        .start_pulse (start_pulse),
        .run_active  (run_active),
        .node_idx    (node_idx),
        .run_done    (run_done),
        .timeout_err (timeout_err)
    );

    always #10 clk_50M = ~clk_50M;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    // Raise run_req; start_pulse appears on the third edge, then one more edge
    task automatic start_run(input logic [5:0] n);
        num_nodes = n;
        run_req   = 1'b1;
        tick(2);
        tests++; if (start_pulse !== 1'b0) begin failed++; $display("FAIL start_early got %b exp 0", start_pulse); end
        tick(1);
        tests++; if (start_pulse !== 1'b1) begin failed++; $display("FAIL start_pulse got %b exp 1", start_pulse); end
        tick(1);
        tests++; if (start_pulse !== 1'b0) begin failed++; $display("FAIL start_width got %b exp 0", start_pulse); end
    endtask

    // One-cycle node_reached pulse
    task automatic pulse_node();
        node_reached = 1'b1;
        tick(1);
        node_reached = 1'b0;
    endtask

    // Drop run_req and verify return to IDLE with every output cleared
    task automatic drop_req();
        run_req = 1'b0;
        tick(3);
        tests++;
        if ({start_pulse, run_active, run_done, timeout_err, node_idx} !== 10'd0) begin
            failed++;
            $display("FAIL drop_idle got sp=%b ra=%b rd=%b te=%b idx=%0d exp all 0",
                     start_pulse, run_active, run_done, timeout_err, node_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run_req = 1'b0;
        tick(3);
        tests++;
        if ({start_pulse, run_active, run_done, timeout_err, node_idx} !== 10'd0) begin
            failed++;
            $display("FAIL reset got sp=%b ra=%b rd=%b te=%b idx=%0d exp all 0",
                     start_pulse, run_active, run_done, timeout_err, node_idx);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_full_run();
        start_run(6'd3);
        tests++; if (run_active !== 1'b1) begin failed++; $display("FAIL run_active got %b exp 1", run_active); end
        for (int k = 1; k <= 3; k++) begin
            tick(9);
            pulse_node();
            tests++; if (node_idx !== 6'(k)) begin failed++; $display("FAIL node_idx_%0d got %0d exp %0d", k, node_idx, k); end
        end
        tests++; if (run_done !== 1'b1) begin failed++; $display("FAIL run_done got %b exp 1", run_done); end
        tests++; if (run_active !== 1'b0) begin failed++; $display("FAIL done_active got %b exp 0", run_active); end
        pulse_node();
        tests++; if (node_idx !== 6'd3) begin failed++; $display("FAIL done_hold got %0d exp 3", node_idx); end
        drop_req();
    endtask

    task automatic test_zero_nodes();
        int seen_active = 0;
        num_nodes = 6'd0;
        run_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (run_active) seen_active++;
        end
        tests++; if (start_pulse !== 1'b1) begin failed++; $display("FAIL zero_start got %b exp 1", start_pulse); end
        tick(1);
        if (run_active) seen_active++;
        tests++; if (run_done !== 1'b1) begin failed++; $display("FAIL zero_done got %b exp 1", run_done); end
        tick(3);
        if (run_active) seen_active++;
        tests++; if (seen_active !== 0) begin failed++; $display("FAIL zero_active got %0d exp 0", seen_active); end
        drop_req();
    endtask

    task automatic test_timeout();
        start_run(6'd5);
        pulse_node();
        tick(15);
        tests++; if (timeout_err !== 1'b0) begin failed++; $display("FAIL to_early got %b exp 0", timeout_err); end
        tick(1);
        tests++; if (timeout_err !== 1'b1) begin failed++; $display("FAIL to_fault got %b exp 1", timeout_err); end
        tests++; if (node_idx !== 6'd1) begin failed++; $display("FAIL to_idx got %0d exp 1", node_idx); end
        tests++; if (run_active !== 1'b0) begin failed++; $display("FAIL to_active got %b exp 0", run_active); end
        drop_req();
        // Pulse landing exactly on the 16th cycle must count instead of faulting
        start_run(6'd5);
        pulse_node();
        tick(15);
        pulse_node();
        tests++; if (timeout_err !== 1'b0) begin failed++; $display("FAIL to_edge_err got %b exp 0", timeout_err); end
        tests++; if (node_idx !== 6'd2) begin failed++; $display("FAIL to_edge_idx got %0d exp 2", node_idx); end
        tests++; if (run_active !== 1'b1) begin failed++; $display("FAIL to_edge_active got %b exp 1", run_active); end
        drop_req();
    endtask

    task automatic test_abort();
        start_run(6'd5);
        pulse_node();
        pulse_node();
        tests++; if (node_idx !== 6'd2) begin failed++; $display("FAIL abort_pre got %0d exp 2", node_idx); end
        run_req = 1'b0;
        tick(2);
        tests++; if (run_active !== 1'b1) begin failed++; $display("FAIL abort_latency got %b exp 1", run_active); end
        // Fall is detected on this edge; a simultaneous node event must be dropped
        node_reached = 1'b1;
        tick(1);
        node_reached = 1'b0;
        tests++; if ({run_active, node_idx} !== 7'd0) begin failed++; $display("FAIL abort_idle got ra=%b idx=%0d exp 0", run_active, node_idx); end
        tick(2);
        start_run(6'd5);
        pulse_node();
        rst     = 1'b1;
        run_req = 1'b0;
        tick(1);
        tests++;
        if ({start_pulse, run_active, run_done, timeout_err, node_idx} !== 10'd0) begin
            failed++;
            $display("FAIL mid_rst got sp=%b ra=%b rd=%b te=%b idx=%0d exp all 0",
                     start_pulse, run_active, run_done, timeout_err, node_idx);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_glitch_and_latch();
        int starts = 0;
        int actives = 0;
        num_nodes = 6'd4;
        run_req   = 1'b1;
        tick(1);
        run_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (start_pulse) starts++;
            if (run_active) actives++;
        end
        tests++; if (starts !== 1) begin failed++; $display("FAIL glitch_starts got %0d exp 1", starts); end
        tests++; if (actives !== 0) begin failed++; $display("FAIL glitch_active got %0d exp 0", actives); end
        start_run(6'd3);
        num_nodes = 6'd1;
        pulse_node();
        tests++; if (run_done !== 1'b0) begin failed++; $display("FAIL latch_early_done got %b exp 0", run_done); end
        pulse_node();
        pulse_node();
        tests++; if (run_done !== 1'b1 || node_idx !== 6'd3) begin failed++; $display("FAIL latch_done got rd=%b idx=%0d exp 1/3", run_done, node_idx); end
        drop_req();
    endtask

    task automatic test_back_to_back();
        start_run(6'd1);
        pulse_node();
        tests++; if (run_done !== 1'b1) begin failed++; $display("FAIL b2b_first got %b exp 1", run_done); end
        drop_req();
        start_run(6'd2);
        tests++; if (node_idx !== 6'd0 || run_active !== 1'b1) begin failed++; $display("FAIL b2b_second got idx=%0d ra=%b exp 0/1", node_idx, run_active); end
        pulse_node();
        pulse_node();
        tests++; if (run_done !== 1'b1 || node_idx !== 6'd2) begin failed++; $display("FAIL b2b_done got rd=%b idx=%0d exp 1/2", run_done, node_idx); end
        drop_req();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_zero_nodes();
        test_timeout();
        test_abort();
        test_glitch_and_latch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
